// File: rtl/diffusion_iter.sv
// diffusion_iter: iterative AES ShiftRows+MixColumns (enc) / InvMixColumns+InvShiftRows (dec) stage.
// Mixes COLS_PER_CYCLE columns per clock; skip_mix gives the final-round row permutation only.
module diffusion_iter #(
  parameter int unsigned COLS_PER_CYCLE = 1,
  parameter bit          INV_EN         = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         dec,
  input  logic         skip_mix,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int unsigned NCYC = 4 / COLS_PER_CYCLE;
  localparam int unsigned CW   = 2;
  localparam int unsigned SW   = 128;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
    $error("diffusion_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // Column in {a3,a2,a1,a0} (a3 = top); coefficient for output t, input u is base[(u - t) mod 4].
  function automatic logic [31:0] mix_col(input logic [31:0] a, input logic inv);
    logic [7:0]  x, x2, x4, x8;
    logic [7:0]  p [4][4];
    logic [31:0] o;
    for (int u = 0; u < 4; u++) begin
      x  = a[8*(3-u) +: 8];
      x2 = xtime(x);
      x4 = xtime(x2);
      x8 = xtime(x4);
      if (inv) begin
        p[u][0] = x8 ^ x4 ^ x2;
        p[u][1] = x8 ^ x2 ^ x;
        p[u][2] = x8 ^ x4 ^ x;
        p[u][3] = x8 ^ x;
      end else begin
        p[u][0] = x2;
        p[u][1] = x2 ^ x;
        p[u][2] = x;
        p[u][3] = x;
      end
    end
    o = '0;
    for (int t = 0; t < 4; t++) begin
      for (int u = 0; u < 4; u++) begin
        o[8*(3-t) +: 8] = o[8*(3-t) +: 8] ^ p[u][2'(u - t)];
      end
    end
    return o;
  endfunction

  // Row r rotates by 3-r; forward pulls from column c-k, inverse from c+k.
  function automatic logic [SW-1:0] shift_rows(input logic [SW-1:0] s, input logic inv);
    logic [SW-1:0] o;
    logic [1:0]    src;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        src = inv ? 2'(c + 3 - r) : 2'(c - 3 + r);
        o[8*(4*r+c) +: 8] = s[8*(4*r+int'(src)) +: 8];
      end
    end
    return o;
  endfunction

  logic [1:0]    r_fsm;
  logic [SW-1:0] r_state;
  logic [CW-1:0] r_col_cnt;
  logic          r_dec;
  logic          r_skip;
  logic          r_live;

  logic [1:0]    w_fsm_nxt;
  logic [SW-1:0] w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_dec_nxt;
  logic          w_skip_nxt;
  logic          w_accept;
  logic          w_dec_in;
  logic          w_dec_q;
  logic [SW-1:0] w_sr_in;
  logic [SW-1:0] w_mixed;

  assign w_dec_in  = INV_EN && dec;
  assign w_dec_q   = INV_EN && r_dec;
  assign in_ready  = r_live & ((r_fsm == S_IDLE) | ((r_fsm == S_DONE) & out_ready));
  assign w_accept  = in_valid & in_ready;
  assign w_sr_in   = shift_rows(in_state, 1'b0);
  assign out_valid = (r_fsm == S_DONE);
  assign busy      = (r_fsm != S_IDLE);
  assign out_state = w_dec_q ? shift_rows(r_state, 1'b1) : r_state;

  // Mix the current group of columns in place.
  always_comb begin : mix_dp
    logic [1:0]  idx;
    logic [31:0] col;
    logic [31:0] mixed;
    idx     = '0;
    col     = '0;
    mixed   = '0;
    w_mixed = r_state;
    for (int j = 0; j < int'(COLS_PER_CYCLE); j++) begin
      idx = 2'(3 - int'(r_col_cnt) * int'(COLS_PER_CYCLE) - j);
      for (int r = 0; r < 4; r++) begin
        col[8*r +: 8] = r_state[8*(4*r+int'(idx)) +: 8];
      end
      mixed = mix_col(col, w_dec_q);
      for (int r = 0; r < 4; r++) begin
        w_mixed[8*(4*r+int'(idx)) +: 8] = mixed[8*r +: 8];
      end
    end
  end

  always_comb begin : fsm_next
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_col_cnt;
    w_dec_nxt   = r_dec;
    w_skip_nxt  = r_skip;
    case (r_fsm)
      S_IDLE: ;
      S_RUN: begin
        w_state_nxt = r_skip ? r_state : w_mixed;
        w_cnt_nxt   = CW'(r_col_cnt + 1'b1);
        if (r_skip || (r_col_cnt == CW'(NCYC - 1))) w_fsm_nxt = S_DONE;
      end
      S_DONE: if (out_ready) w_fsm_nxt = S_IDLE;
      default: w_fsm_nxt = S_IDLE;
    endcase
    // A new state may be taken from IDLE or in the same cycle DONE is drained.
    if (w_accept) begin
      w_state_nxt = w_dec_in ? in_state : w_sr_in;
      w_dec_nxt   = w_dec_in;
      w_skip_nxt  = skip_mix;
      w_cnt_nxt   = '0;
      w_fsm_nxt   = skip_mix ? S_DONE : S_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm     <= S_IDLE;
      r_state   <= '0;
      r_col_cnt <= '0;
      r_dec     <= 1'b0;
      r_skip    <= 1'b0;
      r_live    <= 1'b0;
    end else begin
      r_fsm     <= w_fsm_nxt;
      r_state   <= w_state_nxt;
      r_col_cnt <= w_cnt_nxt;
      r_dec     <= w_dec_nxt;
      r_skip    <= w_skip_nxt;
      r_live    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_diffusion_iter.sv
// Scoreboard bench for diffusion_iter: three instances (1, 2, 4 columns per cycle) checked
// against hand-computed AES vectors, with latency measured from the accept edge.
module tb_diffusion_iter;

  typedef struct {
    logic [127:0] st;
    int           lat;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         v0, v12;
  logic         dec, skip_mix, out_ready;
  logic [127:0] in_state;
  logic [2:0]   rdy, ovl, bsy, vin;
  logic [127:0] ost [3];

  exp_t sb [3][$];
  int   acc_q [3][$];
  logic [2:0] seen;
  int   cyc;
  int   n_tests;
  int   n_fail;

  localparam logic [127:0] T1_IN  = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [127:0] T1_EXP = 128'h0f0e0d0c_0a09080b_05040706_00030201;
  localparam logic [127:0] T2A_IN = 128'hdbdbdbdb_13131313_53535353_45454545;
  localparam logic [127:0] T2A_EX = 128'h8e8e8e8e_4d4d4d4d_a1a1a1a1_bcbcbcbc;
  localparam logic [127:0] T2B_IN = 128'hf2f2f2f2_0a0a0a0a_22222222_5c5c5c5c;
  localparam logic [127:0] T2B_EX = 128'h9f9f9f9f_dcdcdcdc_58585858_9d9d9d9d;
  localparam logic [127:0] T2C    = 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6;

  assign vin = {v12, v12, v0};

  diffusion_iter #(.COLS_PER_CYCLE(1), .INV_EN(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy[0]), .in_state(in_state),
    .dec(dec), .skip_mix(skip_mix), .out_valid(ovl[0]), .out_ready(out_ready),
    .out_state(ost[0]), .busy(bsy[0]));
  diffusion_iter #(.COLS_PER_CYCLE(2), .INV_EN(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v12), .in_ready(rdy[1]), .in_state(in_state),
    .dec(dec), .skip_mix(skip_mix), .out_valid(ovl[1]), .out_ready(out_ready),
    .out_state(ost[1]), .busy(bsy[1]));
  diffusion_iter #(.COLS_PER_CYCLE(4), .INV_EN(1'b1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v12), .in_ready(rdy[2]), .in_state(in_state),
    .dec(dec), .skip_mix(skip_mix), .out_valid(ovl[2]), .out_ready(out_ready),
    .out_state(ost[2]), .busy(bsy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIPS-197 strings (column-major, first byte in the MSB) into this block's byte layout.
  function automatic logic [127:0] tr(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        o[8*(15-4*i-j) +: 8] = s[8*(15-(4*j+i)) +: 8];
      end
    end
    return o;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s got %h required %h", nm, got, req);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s got %b required %b", nm, got, req);
    end
  endtask

  task automatic chkn(input string nm, input int got, input int req);
    n_tests++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s got %0d required %0d", nm, got, req);
    end
  endtask

  // Monitor: latency and data checked on the first valid cycle of each result, popped on handshake.
  initial begin
    seen = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < 3; i++) begin
          sb[i].delete();
          acc_q[i].delete();
          seen[i] = 1'b0;
        end
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (ovl[i]) begin
            if (sb[i].size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL unexpected_out dut%0d got %h required no output", i, ost[i]);
            end else begin
              if (!seen[i]) begin
                chkn($sformatf("latency dut%0d", i),
                     (acc_q[i].size() > 0) ? cyc - acc_q[i][0] : -1, sb[i][0].lat);
                chk($sformatf("data dut%0d", i), ost[i], sb[i][0].st);
                seen[i] = 1'b1;
              end
              if (out_ready) begin
                void'(sb[i].pop_front());
                if (acc_q[i].size() > 0) void'(acc_q[i].pop_front());
                seen[i] = 1'b0;
              end
            end
          end
          if (vin[i] && rdy[i]) acc_q[i].push_back(cyc);
        end
      end
    end
  end

  task automatic send(input logic [127:0] st, input logic d, input logic sk,
                      input logic [127:0] exp_st, input int lat, output int waits);
    exp_t e;
    bit   ok;
    e.st  = exp_st;
    e.lat = lat;
    sb[0].push_back(e);
    in_state = st;
    dec      = d;
    skip_mix = sk;
    v0       = 1'b1;
    waits    = 0;
    ok       = 1'b0;
    while (!ok && waits < 100) begin
      @(negedge clk);
      if (rdy[0]) ok = 1'b1;
      else waits++;
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout got in_ready=0 required in_ready=1");
    end
    @(posedge clk);
    #1;
    v0 = 1'b0;
  endtask

  task automatic send_all(input logic [127:0] st, input logic d, input logic [127:0] exp_st);
    exp_t e;
    bit   ok;
    e.st = exp_st;
    e.lat = 5; sb[0].push_back(e);
    e.lat = 3; sb[1].push_back(e);
    e.lat = 2; sb[2].push_back(e);
    in_state = st;
    dec      = d;
    skip_mix = 1'b0;
    v0       = 1'b1;
    v12      = 1'b1;
    ok       = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (&rdy) ok = 1'b1;
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL sweep_accept_timeout got in_ready=%b required 111", rdy);
    end
    @(posedge clk);
    #1;
    v0  = 1'b0;
    v12 = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      if (sb[0].size() == 0 && sb[1].size() == 0 && sb[2].size() == 0) ok = 1'b1;
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout got %0d pending required 0", sb[0].size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog got timeout required completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0; v0 = 1'b0; v12 = 1'b0; dec = 1'b0; skip_mix = 1'b0;
    out_ready = 1'b1; in_state = '0;
    #3;
    chk1("rst_in_ready", rdy[0], 1'b0);
    chk1("rst_out_valid", ovl[0], 1'b0);
    chk1("rst_busy", bsy[0], 1'b0);
    chk("rst_out_state", ost[0], '0);
    #19;
    rst_n = 1'b1;
    #1;
    chk1("in_ready_before_first_clk", rdy[0], 1'b0);
    @(posedge clk);
    #1;
    chk1("in_ready_after_first_clk", rdy[0], 1'b1);

    // Final-round ShiftRows only, then enc column vectors back to back.
    send(T1_IN, 1'b0, 1'b1, T1_EXP, 1, w);
    send(T2A_IN, 1'b0, 1'b0, T2A_EX, 5, w);
    send(T2B_IN, 1'b0, 1'b0, T2B_EX, 5, w);
    send(T2C, 1'b0, 1'b0, T2C, 5, w);
    send(tr(128'hd42711aee0bf98f1b8b45de51e415230), 1'b0, 1'b0,
         tr(128'h046681e5e0cb199a48f8d37a2806264c), 5, w);
    send(tr(128'hd42711aee0bf98f1b8b45de51e415230), 1'b0, 1'b1,
         tr(128'hd4bf5d30e0b452aeb84111f11e2798e5), 1, w);
    // Inverse direction recovers the originals.
    send(T2A_EX, 1'b1, 1'b0, T2A_IN, 5, w);
    send(T2B_EX, 1'b1, 1'b0, T2B_IN, 5, w);
    send(T2C, 1'b1, 1'b0, T2C, 5, w);
    send(tr(128'h046681e5e0cb199a48f8d37a2806264c), 1'b1, 1'b0,
         tr(128'hd42711aee0bf98f1b8b45de51e415230), 5, w);
    send(tr(128'hd4bf5d30e0b452aeb84111f11e2798e5), 1'b1, 1'b1,
         tr(128'hd42711aee0bf98f1b8b45de51e415230), 1, w);
    wait_idle();

    // Backpressure hold, then drain and accept in the same cycle.
    out_ready = 1'b0;
    send(T2A_IN, 1'b0, 1'b0, T2A_EX, 5, w);
    for (int k = 0; k < 20 && !ovl[0]; k++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_out_state", ost[0], T2A_EX);
      chk1("hold_out_valid", ovl[0], 1'b1);
      chk1("hold_in_ready", rdy[0], 1'b0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(T2B_IN, 1'b0, 1'b0, T2B_EX, 5, w);
    chkn("no_bubble_wait_cycles", w, 0);
    wait_idle();

    // Reset in the middle of a mix discards the in-flight state.
    send(T2A_IN, 1'b0, 1'b0, T2A_EX, 5, w);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk1("midrun_rst_out_valid", ovl[0], 1'b0);
    chk1("midrun_rst_busy", bsy[0], 1'b0);
    chk1("midrun_rst_in_ready", rdy[0], 1'b0);
    chk("midrun_rst_state", ost[0], '0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk1("aborted_no_output", ovl[0], 1'b0);
    end
    @(posedge clk);
    #1;
    send(T2B_IN, 1'b0, 1'b0, T2B_EX, 5, w);
    wait_idle();

    // Same stimulus into 1/2/4 columns-per-cycle instances.
    send_all(T2A_IN, 1'b0, T2A_EX);
    wait_idle();
    send_all(tr(128'h046681e5e0cb199a48f8d37a2806264c), 1'b1,
             tr(128'hd42711aee0bf98f1b8b45de51e415230));
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
